// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: combinational hit path and a
// three-state miss FSM that fetches a whole 16-byte block from instruction memory.
module instruction_cache #(
    parameter int N_BLOCKS = 8,
    parameter int INDEX_W  = 3,
    parameter int TAG_W    = 10 - 4 - INDEX_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                first_q, first_d;
    logic [N_BLOCKS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [N_BLOCKS];
    logic [127:0]        data_q [N_BLOCKS];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    addr_tag;
    logic [127:0]        line;
    logic                hit;
    logic                fill_en;
    logic                unused_bits;

    assign idx         = address[INDEX_W+3:4];
    assign addr_tag    = address[9:INDEX_W+4];
    assign line        = data_q[idx];
    assign hit         = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign instruction = line[32*address[3:2] +: 32];
    assign mem_address = address[9:4];
    assign dbg_state   = state_q;
    assign unused_bits = ^address[1:0];

    // Memory only raises mem_busywait after it has seen mem_read, so the first
    // MEM_READ cycle never accepts data (first_q masks the stale low level).
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        valid_d  = valid_q;
        fill_en  = 1'b0;
        mem_read = 1'b0;
        busywait = 1'b1;
        case (state_q)
            IDLE: begin
                busywait = !hit;
                if (!hit) begin
                    state_d = MEM_READ;
                    first_d = 1'b1;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                first_d  = 1'b0;
                if (!first_q && !mem_busywait) begin
                    state_d      = UPDATE;
                    fill_en      = 1'b1;
                    valid_d[idx] = 1'b1;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            busywait = 1'b0;
            mem_read = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[idx]  <= addr_tag;
            data_q[idx] <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios plus random fetches checked
// against a block-number map of cache contents and a simple block memory.
module tb_instruction_cache;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [9:0]   address = '0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;

    logic [127:0] mem [64];
    int           model_blk [8];

    instruction_cache dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .dbg_state    (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_blk[i] = -1;
    endtask

    // Called right after a falling edge with the cache idle; returns at a
    // falling edge with the cache idle again.
    task automatic fetch(input logic [9:0] a, input int lat);
        int           blk;
        int           idx;
        logic [127:0] blk_data;
        logic [31:0]  exp_word;
        bit           exp_hit;
        blk      = int'(a[9:4]);
        idx      = blk % 8;
        blk_data = mem[blk];
        exp_word = blk_data[32*a[3:2] +: 32];
        exp_hit  = (model_blk[idx] == blk);
        address  = a;
        #1;
        check("busywait_at_fetch", 32'(busywait), 32'(!exp_hit));
        if (exp_hit) begin
            check("hit_instruction", instruction, exp_word);
            check("hit_mem_read", 32'(mem_read), 32'd0);
            @(negedge clock);
        end else begin
            check("miss_mem_read_idle", 32'(mem_read), 32'd0);
            @(negedge clock);
            check("mr_first_read", 32'(mem_read), 32'd1);
            check("mr_first_addr", 32'(mem_address), 32'(blk));
            check("mr_first_busy", 32'(busywait), 32'd1);
            mem_busywait = 1'b0;
            mem_readdata = ~blk_data;
            for (int i = 0; i < lat; i++) begin
                @(negedge clock);
                check("mr_wait_read", 32'(mem_read), 32'd1);
                check("mr_wait_addr", 32'(mem_address), 32'(blk));
                check("mr_wait_busy", 32'(busywait), 32'd1);
                mem_busywait = 1'b1;
                mem_readdata = ~blk_data;
            end
            @(negedge clock);
            check("mr_last_read", 32'(mem_read), 32'd1);
            check("mr_last_addr", 32'(mem_address), 32'(blk));
            mem_busywait = 1'b0;
            mem_readdata = blk_data;
            @(negedge clock);
            check("upd_mem_read", 32'(mem_read), 32'd0);
            check("upd_busy", 32'(busywait), 32'd1);
            mem_readdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clock);
            check("fill_busy", 32'(busywait), 32'd0);
            check("fill_mem_read", 32'(mem_read), 32'd0);
            check("fill_instruction", instruction, exp_word);
            model_blk[idx] = blk;
        end
    endtask

    // Starts a miss, pulses reset while memory is busy, returns at a falling
    // edge with reset just released.
    task automatic miss_then_reset(input logic [9:0] a);
        address = a;
        #1;
        check("rst_pre_busy", 32'(busywait), 32'd1);
        @(negedge clock);
        check("rst_pre_read", 32'(mem_read), 32'd1);
        mem_busywait = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_read", 32'(mem_read), 32'd0);
        check("rst_mid_busy", 32'(busywait), 32'd0);
        @(negedge clock);
        check("rst_held_busy", 32'(busywait), 32'd0);
        mem_busywait = 1'b0;
        reset        = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [9:0] ra;
        for (int b = 0; b < 64; b++)
            mem[b] = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
        model_clear();

        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busywait), 32'd0);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        reset = 1'b0;

        fetch(10'h000, 2);
        check("t1_word0", instruction, 32'h00000001);
        fetch(10'h004, 0);
        fetch(10'h008, 0);
        fetch(10'h00C, 0);
        fetch(10'h00E, 0);

        fetch(10'h080, 1);
        fetch(10'h000, 0);
        fetch(10'h080, 3);

        miss_then_reset(10'h000);
        fetch(10'h000, 1);

        fetch(10'h3F4, 40);
        fetch(10'h3F0, 0);

        for (int n = 0; n < 80; n++) begin
            ra = {6'($urandom_range(0, 11) * 5), 4'($urandom_range(0, 15))};
            fetch(ra, int'($urandom_range(0, 4)));
        end

        miss_then_reset(10'h124);
        for (int n = 0; n < 20; n++) begin
            ra = {6'($urandom_range(16, 23)), 4'($urandom_range(0, 15))};
            fetch(ra, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
